// File: rtl/operator_arbiter.sv
// ---------------------------------------------------------------------------
// operator_arbiter
//
// Two-requester front end for a 16-bit reversible carry-skip add/subtract
// operator. Requesters are granted round-robin. A narrow (16-bit) operation
// takes one pass through the operator. A wide (32-bit) operation takes two
// passes, and the carry/borrow from the low half chains into the high half.
// The result is returned on one valid/ready response channel, tagged with
// the id of the requester that issued it.
//
// Parameters:
//   WIDE_EN      when 0, reqN_wide is ignored and every operation is narrow
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   reqN_valid   requester N has an operation (N = 0, 1)
//   reqN_ready   requester N is granted; the handshake is valid & ready
//   reqN_a/b     32-bit operands (a narrow operation uses [15:0])
//   reqN_r       0 = add, 1 = subtract (a - b - borrow)
//   reqN_cbin    carry-in for add, borrow-in for subtract
//   reqN_wide    1 = 32-bit two-pass operation
//   rsp_valid    a response is available
//   rsp_ready    the consumer accepts the response
//   rsp_id       requester that issued the operation
//   rsp_result   result; [31:16] is 0 for a narrow operation
//   rsp_cbout    final carry-out (add) or borrow-out (subtract)
//   busy         high whenever the sequencer is not idle
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// ReversibleCarrySkipOperator_16bits
//
// Functional model of the 16-bit reversible carry-skip adder/subtractor.
// Subtraction is done as a + ~b + ~borrow, and the final carry is inverted
// to give the borrow. The adder is split into four 4-bit blocks. If a block
// propagates on every bit, its incoming carry skips straight past the
// block's ripple chain.
//
// Ports:
//   a, b         16-bit operands
//   r            0 = add, 1 = subtract
//   cbin         carry-in (add) / borrow-in (subtract)
//   s            16-bit sum / difference
//   cbout        carry-out (add) / borrow-out (subtract)
// ---------------------------------------------------------------------------
module ReversibleCarrySkipOperator_16bits (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        r,
   input  logic        cbin,
   output logic [15:0] s,
   output logic        cbout
);

   logic [15:0] b_eff;
   logic [15:0] p;
   logic [15:0] g;

   assign b_eff = r ? ~b : b;
   assign p     = a ^ b_eff;
   assign g     = a & b_eff;

   // Each block ripples internally. The block's carry-out is taken from the
   // skip path when every bit of the block propagates. Both paths give the
   // same value, so the skip path only shortens the critical path. The
   // carry is kept in scalar variables so that no vector feeds back on itself.
   always_comb begin
      logic c_blk;
      logic c_in;
      logic ripple;
      s      = '0;
      c_blk  = r ? ~cbin : cbin;
      c_in   = 1'b0;
      ripple = 1'b0;
      for (int k = 0; k < 4; k++) begin
         c_in   = c_blk;
         ripple = c_in;
         for (int j = 0; j < 4; j++) begin
            s[4*k+j] = p[4*k+j] ^ ripple;
            ripple   = g[4*k+j] | (p[4*k+j] & ripple);
         end
         c_blk = (&p[4*k +: 4]) ? c_in : ripple;
      end
      cbout = r ? ~c_blk : c_blk;
   end

endmodule

module operator_arbiter #(
   parameter bit WIDE_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_r,
   input  logic        req0_cbin,
   input  logic        req0_wide,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_r,
   input  logic        req1_cbin,
   input  logic        req1_wide,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_cbout,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

   state_t state;
   state_t state_next;

   logic        accept;
   logic        grant_id;
   logic        last_grant;

   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        r_q;
   logic        cbin_q;
   logic        wide_q;
   logic        id_q;
   logic        carry_q;
   logic [31:0] result_q;
   logic        cbout_q;

   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic        sel_r;
   logic        sel_cbin;
   logic        sel_wide;

   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        op_cbin;
   logic [15:0] op_s;
   logic        op_cbout;

   // Operand fields of whichever requester wins arbitration this cycle.
   assign sel_a    = grant_id ? req1_a    : req0_a;
   assign sel_b    = grant_id ? req1_b    : req0_b;
   assign sel_r    = grant_id ? req1_r    : req0_r;
   assign sel_cbin = grant_id ? req1_cbin : req0_cbin;
   assign sel_wide = grant_id ? req1_wide : req0_wide;

   // The high half of a wide operation takes its carry/borrow from the
   // low-half pass, not from the requester's cbin.
   assign op_a    = (state == HIGH) ? a_q[31:16] : a_q[15:0];
   assign op_b    = (state == HIGH) ? b_q[31:16] : b_q[15:0];
   assign op_cbin = (state == HIGH) ? carry_q    : cbin_q;

   ReversibleCarrySkipOperator_16bits u_operator (
      .a     (op_a),
      .b     (op_b),
      .r     (r_q),
      .cbin  (op_cbin),
      .s     (op_s),
      .cbout (op_cbout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and grant logic. A grant exists only in IDLE and only for
   // the current cycle. On a tie, the requester that did not win last time
   // is served. Ready is held low while rst is asserted.
   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      grant_id   = 1'b0;
      case (state)
         IDLE: begin
            if (!rst) begin
               if (req0_valid && (!req1_valid || last_grant)) begin
                  req0_ready = 1'b1;
                  accept     = 1'b1;
                  grant_id   = 1'b0;
               end else if (req1_valid) begin
                  req1_ready = 1'b1;
                  accept     = 1'b1;
                  grant_id   = 1'b1;
               end
            end
            if (accept) begin
               state_next = LOW;
            end
         end
         LOW: begin
            state_next = wide_q ? HIGH : RESP;
         end
         HIGH: begin
            state_next = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand latch, grant history and result registers. The whole result
   // is cleared at accept, so a narrow operation's upper half reads as
   // zero without any extra work in LOW.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= 1'b0;
         cbin_q     <= 1'b0;
         wide_q     <= 1'b0;
         id_q       <= 1'b0;
         carry_q    <= 1'b0;
         result_q   <= '0;
         cbout_q    <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q        <= sel_a;
                  b_q        <= sel_b;
                  r_q        <= sel_r;
                  cbin_q     <= sel_cbin;
                  wide_q     <= WIDE_EN & sel_wide;
                  id_q       <= grant_id;
                  last_grant <= grant_id;
                  result_q   <= '0;
                  cbout_q    <= 1'b0;
               end
            end
            LOW: begin
               result_q[15:0] <= op_s;
               carry_q        <= op_cbout;
               if (!wide_q) begin
                  cbout_q <= op_cbout;
               end
            end
            HIGH: begin
               result_q[31:16] <= op_s;
               cbout_q         <= op_cbout;
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs are forced to zero while rst is held high.
   assign rsp_valid  = (state == RESP) && !rst;
   assign busy       = (state != IDLE) && !rst;
   assign rsp_id     = rst ? 1'b0  : id_q;
   assign rsp_result = rst ? 32'h0 : result_q;
   assign rsp_cbout  = rst ? 1'b0  : cbout_q;

endmodule

// File: tb/tb_operator_arbiter.sv
// ---------------------------------------------------------------------------
// tb_operator_arbiter
//
// Directed self-checking bench for operator_arbiter. Each scenario task
// drives its own stimulus and compares the outputs against hand-computed
// values. Inputs change, and outputs are sampled, on or just after the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_operator_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic        req0_r, req0_cbin, req0_wide;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic        req1_r, req1_cbin, req1_wide;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_cbout, busy;
   logic [31:0] rsp_result;

   int checks = 0;
   int passed = 0;

   operator_arbiter #(.WIDE_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_r     (req0_r),
      .req0_cbin  (req0_cbin),
      .req0_wide  (req0_wide),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_r     (req1_r),
      .req1_cbin  (req1_cbin),
      .req1_wide  (req1_wide),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_cbout  (rsp_cbout),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Drives one operation on the given requester with rsp_ready held high.
   // Returns the captured response fields and the latency in rising edges,
   // counted from the accept edge. lat = -1 means the operation was never
   // granted or never answered.
   task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic r, input logic cbin, input logic wide,
                        output logic [31:0] res, output logic cb, output logic rid,
                        output int lat);
      int n;
      res = 'x;
      cb  = 1'bx;
      rid = 1'bx;
      @(negedge clk);
      rsp_ready = 1'b1;
      if (id) begin
         req1_a = a; req1_b = b; req1_r = r; req1_cbin = cbin; req1_wide = wide;
         req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_r = r; req0_cbin = cbin; req0_wide = wide;
         req0_valid = 1'b1;
      end
      n = 0;
      #1;
      while (!(id ? req1_ready : req0_ready) && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      if (!(id ? req1_ready : req0_ready)) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         lat = -1;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         lat = -1;
      end else begin
         res = rsp_result;
         cb  = rsp_cbout;
         rid = rsp_id;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      req0_a = '0; req0_b = '0; req0_r = 1'b0; req0_cbin = 1'b0; req0_wide = 1'b0;
      req1_a = '0; req1_b = '0; req1_r = 1'b0; req1_cbin = 1'b0; req1_wide = 1'b0;
      repeat (2) @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready, rsp_valid, busy, rsp_id, rsp_cbout} !== 6'b0 || rsp_result !== 32'h0) begin
         $display("[TB] FAIL reset_outputs_zero: got rdy=%b%b vld=%b busy=%b res=%h, expected all 0",
                  req0_ready, req1_ready, rsp_valid, busy, rsp_result);
      end else passed++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         $display("[TB] FAIL reset_first_tie: got ready=%b%b, expected 10", req0_ready, req1_ready);
      end else passed++;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checks++;
      if ({rsp_valid, busy} !== 2'b00 || rsp_result !== 32'h0) begin
         $display("[TB] FAIL reset_idle: got vld=%b busy=%b res=%h, expected 0 0 0",
                  rsp_valid, busy, rsp_result);
      end else passed++;
   endtask

   task automatic test_narrow_add();
      logic [31:0] res; logic cb; logic rid; int lat;
      do_op(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, res, cb, rid, lat);
      checks++;
      if (lat !== 2) $display("[TB] FAIL narrow_add_latency: got %0d, expected 2", lat); else passed++;
      checks++;
      if ({res, cb, rid} !== {32'h00000000, 1'b1, 1'b0})
         $display("[TB] FAIL narrow_add: got res=%h cb=%b id=%b, expected 00000000 1 0", res, cb, rid);
      else passed++;
      do_op(1'b1, 32'hABCD0001, 32'h12340002, 1'b0, 1'b0, 1'b0, res, cb, rid, lat);
      checks++;
      if ({res, cb, rid} !== {32'h00000003, 1'b0, 1'b1} || lat !== 2)
         $display("[TB] FAIL narrow_upper_ignored: got res=%h cb=%b id=%b lat=%0d, expected 00000003 0 1 2",
                  res, cb, rid, lat);
      else passed++;
   endtask

   task automatic test_wide_add();
      logic [31:0] res; logic cb; logic rid; int lat;
      do_op(1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, res, cb, rid, lat);
      checks++;
      if (lat !== 3) $display("[TB] FAIL wide_add_latency: got %0d, expected 3", lat); else passed++;
      checks++;
      if ({res, cb, rid} !== {32'h00010000, 1'b0, 1'b1})
         $display("[TB] FAIL wide_add: got res=%h cb=%b id=%b, expected 00010000 0 1", res, cb, rid);
      else passed++;
      do_op(1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, res, cb, rid, lat);
      checks++;
      if ({res, cb, rid} !== {32'h00000000, 1'b1, 1'b0} || lat !== 3)
         $display("[TB] FAIL wide_add_cin_chain: got res=%h cb=%b id=%b lat=%0d, expected 00000000 1 0 3",
                  res, cb, rid, lat);
      else passed++;
   endtask

   task automatic test_sub();
      logic [31:0] res; logic cb; logic rid; int lat;
      do_op(1'b0, 32'h00010000, 32'h00000001, 1'b1, 1'b0, 1'b1, res, cb, rid, lat);
      checks++;
      if ({res, cb} !== {32'h0000FFFF, 1'b0} || lat !== 3)
         $display("[TB] FAIL wide_sub_cross: got res=%h cb=%b lat=%0d, expected 0000ffff 0 3", res, cb, lat);
      else passed++;
      do_op(1'b1, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b1, res, cb, rid, lat);
      checks++;
      if ({res, cb} !== {32'hFFFFFFFF, 1'b1} || lat !== 3)
         $display("[TB] FAIL wide_sub_under: got res=%h cb=%b lat=%0d, expected ffffffff 1 3", res, cb, lat);
      else passed++;
      do_op(1'b0, 32'h00000005, 32'h00000003, 1'b1, 1'b1, 1'b0, res, cb, rid, lat);
      checks++;
      if ({res, cb} !== {32'h00000001, 1'b0} || lat !== 2)
         $display("[TB] FAIL narrow_sub_bin: got res=%h cb=%b lat=%0d, expected 00000001 0 2", res, cb, lat);
      else passed++;
   endtask

   task automatic test_round_robin();
      logic [3:0]  ids;
      logic [31:0] results [4];
      int          got;
      bit          both;
      got  = 0;
      both = 1'b0;
      ids  = '0;
      @(negedge clk);
      rst = 1'b1;
      rsp_ready = 1'b1;
      req0_a = 32'd1;  req0_b = 32'd1;  req0_r = 1'b0; req0_cbin = 1'b0; req0_wide = 1'b0;
      req1_a = 32'd10; req1_b = 32'd20; req1_r = 1'b0; req1_cbin = 1'b0; req1_wide = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 40 && got < 4; n++) begin
         @(negedge clk); #1;
         if (req0_ready && req1_ready) both = 1'b1;
         if (rsp_valid) begin
            ids[got]     = rsp_id;
            results[got] = rsp_result;
            got++;
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checks++;
      if (got !== 4) $display("[TB] FAIL rr_count: got %0d responses, expected 4", got); else passed++;
      checks++;
      if (ids !== 4'b1010) $display("[TB] FAIL rr_order: got ids(3..0)=%b, expected 1010", ids); else passed++;
      checks++;
      if (results[0] !== 32'd2 || results[1] !== 32'd30 || results[2] !== 32'd2 || results[3] !== 32'd30)
         $display("[TB] FAIL rr_results: got %h %h %h %h, expected 2 1e 2 1e",
                  results[0], results[1], results[2], results[3]);
      else passed++;
      checks++;
      if (both !== 1'b0) $display("[TB] FAIL rr_ready_exclusive: got both-ready=%b, expected 0", both); else passed++;
      // Let any operation still in flight drain.
      for (int n = 0; n < 10 && busy; n++) @(negedge clk);
   endtask

   task automatic test_stall();
      int n;
      @(negedge clk);
      rsp_ready = 1'b0;
      req0_a = 32'h00001000; req0_b = 32'h00000234; req0_r = 1'b0; req0_cbin = 1'b0; req0_wide = 1'b0;
      req0_valid = 1'b1;
      n = 0;
      #1;
      while (!req0_ready && n < 20) begin @(negedge clk); #1; n++; end
      checks++;
      if (req0_ready !== 1'b1) $display("[TB] FAIL stall_grant: got ready=%b, expected 1", req0_ready); else passed++;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_a = 32'd7; req1_b = 32'd2; req1_r = 1'b1; req1_cbin = 1'b0; req1_wide = 1'b0;
      req1_valid = 1'b1;
      n = 0;
      #1;
      while (!rsp_valid && n < 10) begin @(negedge clk); #1; n++; end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({rsp_valid, rsp_result, rsp_cbout, rsp_id, req0_ready, req1_ready, busy} !==
             {1'b1, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
            $display("[TB] FAIL stall_hold_%0d: got vld=%b res=%h cb=%b id=%b rdy=%b%b busy=%b, expected 1 00001234 0 0 00 1",
                     k, rsp_valid, rsp_result, rsp_cbout, rsp_id, req0_ready, req1_ready, busy);
         else passed++;
         @(negedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if ({busy, rsp_valid, req1_ready} !== 3'b110)
         $display("[TB] FAIL stall_handshake_cycle: got busy=%b vld=%b rdy1=%b, expected 1 1 0", busy, rsp_valid, req1_ready);
      else passed++;
      @(negedge clk); #1;
      checks++;
      if ({busy, rsp_valid, req1_ready} !== 3'b001)
         $display("[TB] FAIL stall_back_idle: got busy=%b vld=%b rdy1=%b, expected 0 0 1", busy, rsp_valid, req1_ready);
      else passed++;
      @(posedge clk);
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1) $display("[TB] FAIL stall_next_accept: got busy=%b, expected 1", busy); else passed++;
      n = 0;
      while (!rsp_valid && n < 10) begin @(negedge clk); #1; n++; end
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_cbout} !== {1'b1, 1'b1, 32'h00000005, 1'b0})
         $display("[TB] FAIL stall_next_rsp: got vld=%b id=%b res=%h cb=%b, expected 1 1 00000005 0",
                  rsp_valid, rsp_id, rsp_result, rsp_cbout);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      int  n;
      bit  seen;
      @(negedge clk);
      rsp_ready = 1'b1;
      req1_a = 32'h00001234; req1_b = 32'h00000001; req1_r = 1'b0; req1_cbin = 1'b0; req1_wide = 1'b1;
      req1_valid = 1'b1;
      n = 0;
      #1;
      while (!req1_ready && n < 20) begin @(negedge clk); #1; n++; end
      @(posedge clk);
      @(negedge clk);
      req1_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({busy, rsp_valid} !== 2'b10) $display("[TB] FAIL midrst_in_high: got busy=%b vld=%b, expected 1 0", busy, rsp_valid);
      else passed++;
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready, rsp_valid, busy} !== 4'b0000)
         $display("[TB] FAIL midrst_outputs: got rdy=%b%b vld=%b busy=%b, expected 0000",
                  req0_ready, req1_ready, rsp_valid, busy);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (rsp_valid || busy) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) $display("[TB] FAIL midrst_no_response: got activity=%b, expected 0", seen); else passed++;
      req0_a = 32'd2; req0_b = 32'd2; req0_r = 1'b0; req0_cbin = 1'b0; req0_wide = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10)
         $display("[TB] FAIL midrst_tie_req0: got ready=%b%b, expected 10", req0_ready, req1_ready);
      else passed++;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = 0;
      #1;
      while (!rsp_valid && n < 10) begin @(negedge clk); #1; n++; end
      checks++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h00000004})
         $display("[TB] FAIL midrst_after: got vld=%b id=%b res=%h, expected 1 0 00000004",
                  rsp_valid, rsp_id, rsp_result);
      else passed++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_narrow_add();
      test_wide_add();
      test_sub();
      test_round_robin();
      test_stall();
      test_reset_mid_op();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
